mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle core's data-store bus, alongside `dmem`, consuming the same `MemWrite`/`ALUResult`/`WriteData` signals. A store to `TX_ADDR` queues the low byte of the store data in a small FIFO. An FSM serialises each queued byte as an 8N1 frame on `tx`, giving programs a byte output channel with no change to the core. Status outputs report occupancy and a sticky overflow flag.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥2.
- `TX_ADDR`, 32'h8000_0000: data store address; a store here queues a byte.
- `CTRL_ADDR`, 32'h8000_0004: control store address; `WriteData[0]`=1 clears `overflow`.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 at a rising edge resets).
- `MemWrite`  in  1  store strobe from the core.
- `ALUResult`  in  32  store address.
- `WriteData`  in  32  store data; only `[7:0]` is queued.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high when state≠IDLE or FIFO non-empty.
- `fifo_full`  out  1  count == FIFO_DEPTH.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a store to TX_ADDR was dropped.

## Operation
- Push: `MemWrite && ALUResult==TX_ADDR` at an edge. Accepted if the pre-edge count < FIFO_DEPTH, or a pop occurs on the same edge. Otherwise the byte is dropped and `overflow` is set.
- Clear: `MemWrite && ALUResult==CTRL_ADDR && WriteData[0]` clears `overflow`. If a drop occurs on the same edge, the set wins; the clear does not.
- All other addresses are ignored, full 32-bit compare. Byte order and the FIFO are strictly in order.
- FSM states: IDLE, START, DATA, STOP; `parity` state only with the macro.
  - IDLE: if FIFO non-empty, pop into the shift register, go to START; baud counter = 0.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; bit index 0..7, then STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. FIFO pointers wrap modulo FIFO_DEPTH.
- `tx` is registered. Frame length is 10·CLKS_PER_BIT cycles (11· with parity).

## Timing
- Reset (`rst`=0 at an edge):
  - State IDLE; `tx`=1.
  - FIFO empty; `fifo_count`=0, `fifo_full`=0.
  - `overflow`=0, `tx_busy`=0.
  - All counters 0.
- Reset mid-frame aborts the frame. `tx`=1 from the cycle after that edge, and the queued bytes are discarded.
- Pushes during reset are ignored.
- Store at edge k into an empty, idle block:
  - `fifo_count`=1 after edge k.
  - Pop at edge k+1; `fifo_count` returns to 0 after edge k+1.
  - `tx` falls after edge k+1.
- `tx_busy` rises after edge k. It falls after the last STOP cycle when the FIFO is empty.
- Push and pop on the same edge: the count is unchanged.
- `fifo_full` and `fifo_count` update one edge after a push or pop.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11·CLKS_PER_BIT cycles.
- Undefined: no PARITY state or logic; 8N1 frames of 10·CLKS_PER_BIT cycles.

## Test plan
- Reset check, CLKS_PER_BIT=4: hold `rst`=0 three cycles → `tx`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0.
- Single byte: store 32'h1234_5655 to TX_ADDR → after edge k+1, `tx` shows 0,1,0,1,0,1,0,1,0,1, each for 4 cycles (40 cycles); `tx_busy` then 0.
- Back-to-back: stores of 8'hA5 then 8'h3C on consecutive cycles → two frames with no idle gap; second START begins the cycle after the first STOP ends.
- Overflow, DEPTH=4: six consecutive stores while the FIFO is idle-full.
  - Expected: first pushes accepted; drops occur once `fifo_count`=4 with no same-edge pop.
  - `overflow`=1 and stays 1.
  - Then store 1 to CTRL_ADDR → `overflow`=0 next cycle.
- Address filter: stores to TX_ADDR+8 and 32'h0000_0100 → `fifo_count` stays 0, `tx` stays 1.
- Reset mid-frame: `rst`=0 during DATA bit 3 with 2 bytes queued → `tx`=1 and `fifo_count`=0 next cycle; no further frames.
- With `UART_TX_PARITY_EN` defined: store 8'h07 → parity bit = 1; frame is 44 cycles.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-mapped 8N1 UART transmitter with byte FIFO, occupancy status and sticky overflow.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] TX_ADDR      = 32'h8000_0000,
    parameter logic [31:0] CTRL_ADDR    = 32'h8000_0004
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          MemWrite,
    input  logic [31:0]                   ALUResult,
    input  logic [31:0]                   WriteData,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            tx_q, tx_d;
    logic            last, pop, push_req, accept, drop, clr;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    assign last     = baud_q == BW'(CLKS_PER_BIT - 1);
    assign push_req = MemWrite && ALUResult == TX_ADDR;
    assign clr      = MemWrite && ALUResult == CTRL_ADDR && WriteData[0];
    // a same-edge pop frees a slot, so a full FIFO still accepts while draining
    assign accept   = push_req && (count_q < CW'(FIFO_DEPTH) || pop);
    assign drop     = push_req && !accept;
    assign rd_d     = rd_q + PW'(pop);
    assign wr_d     = wr_q + PW'(accept);
    assign count_d  = count_q + CW'(accept) - CW'(pop);
    assign ovf_d    = drop ? 1'b1 : clr ? 1'b0 : ovf_q;

    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE || last) ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:  if (count_q != '0) begin
                pop     = 1'b1;
                state_d = START;
            end
            START: if (last) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA:  if (last) begin
`ifdef UART_TX_PARITY_EN
                state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
                state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
                bit_d   = bit_q + 3'd1;
                shift_d = shift_q >> 1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (last) state_d = STOP;
`endif
            STOP:  if (last) begin
                pop     = count_q != '0;
                state_d = (count_q != '0) ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pop) shift_d = mem_q[rd_q];
    end

`ifdef UART_TX_PARITY_EN
    assign par_d = pop ? ^mem_q[rd_q] : par_q;
    assign tx_d  = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] :
                   (state_d == PARITY) ? par_d : 1'b1;
`else
    assign tx_d  = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst && accept) mem_q[wr_q] <= WriteData[7:0];
    end

    assign tx         = tx_q;
    assign tx_busy    = state_q != IDLE || count_q != '0;
    assign fifo_full  = count_q == CW'(FIFO_DEPTH);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and random stores checked against a queue-based line model.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TXA   = 32'h8000_0000;
    localparam logic [31:0] CTA   = 32'h8000_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic        tx, tx_busy, fifo_full, overflow;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;
    byte unsigned q[$];
    bit line[$];
    bit m_ovf, m_tx, m_busy;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TX_ADDR(TXA), .CTRL_ADDR(CTA)) dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .ALUResult(ALUResult), .WriteData(WriteData),
        .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Whole frame as line samples, one entry per clock cycle.
    task automatic push_frame(input byte unsigned b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) repeat (CPB) line.push_back(bits[i]);
    endtask

    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit act;
        rst = r;
        MemWrite = w;
        ALUResult = a;
        WriteData = d;
        @(posedge clk);
        if (!r) begin
            q.delete();
            line.delete();
            m_ovf = 1'b0;
            m_tx = 1'b1;
            m_busy = 1'b0;
        end else begin
            if (line.size() == 0 && q.size() > 0) push_frame(q.pop_front());
            if (w && a == TXA) begin
                if (q.size() < DEPTH) q.push_back(d[7:0]);
                else m_ovf = 1'b1;
            end else if (w && a == CTA && d[0]) m_ovf = 1'b0;
            act = line.size() > 0;
            m_tx = act ? line.pop_front() : 1'b1;
            m_busy = act || q.size() > 0;
        end
        #1;
        check("tx", 32'(tx), 32'(m_tx));
        check("tx_busy", 32'(tx_busy), 32'(m_busy));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);
        idle(2);
        step(1'b1, 1'b1, TXA, 32'h1234_5655);
        idle(50);
        step(1'b1, 1'b1, TXA, 32'h0000_00A5);
        step(1'b1, 1'b1, TXA, 32'h0000_003C);
        idle(95);
        repeat (6) step(1'b1, 1'b1, TXA, $urandom);
        idle(5);
        step(1'b1, 1'b1, CTA, 32'h0000_0002);
        idle(3);
        step(1'b1, 1'b1, CTA, 32'h0000_0001);
        idle(200);
        step(1'b1, 1'b1, TXA + 32'h8, 32'h55);
        step(1'b1, 1'b1, 32'h0000_0100, 32'h55);
        step(1'b1, 1'b1, TXA | 32'h1_0000, 32'h55);
        idle(5);
        step(1'b1, 1'b1, TXA, 32'h0000_00C3);
        step(1'b1, 1'b1, TXA, 32'h0000_0011);
        step(1'b1, 1'b1, TXA, 32'h0000_0022);
        idle(16);
        step(1'b0, 1'b1, TXA, 32'h0000_0099);
        idle(60);
        step(1'b1, 1'b1, TXA, 32'h0000_0007);
        idle(50);
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = TXA;
                2:       a = CTA;
                3:       a = TXA + 32'(4 * $urandom_range(2, 5));
                default: a = $urandom;
            endcase
            step($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0, a, $urandom);
        end
        idle(100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
